gp_reg_bank: RTL and testbench

//  Parametrised bank of NUM_REGS general-purpose registers on a shared write bus, for datapath

---
 rtl/gp_reg_pkg.sv | 26 ++
 rtl/gp_reg_cell.sv | 45 ++++
 rtl/gp_reg_bank.sv | 51 +++++
 tb/tb_gp_reg_bank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gp_reg_pkg.sv
// Shared op encoding and strobe-priority helper
// for the general-purpose register bank.
package gp_reg_pkg;

   localparam logic [1:0] OP_HOLD = 2'd0;
   localparam logic [1:0] OP_INC  = 2'd1;
   localparam logic [1:0] OP_LOAD = 2'd2;
   localparam logic [1:0] OP_CLR  = 2'd3;

   // clr beats load beats inc; no strobe holds
   function automatic logic [1:0] strobe_op(
      input logic clr,
      input logic load,
      input logic inc
   );
      logic [1:0] op;
      priority case (1'b1)
         clr:     op = OP_CLR;
         load:    op = OP_LOAD;
         inc:     op = OP_INC;
         default: op = OP_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/gp_reg_cell.sv
// One register of the bank: load/clear/increment,
// zero flag and sticky wrap flag.
module gp_reg_cell
   import gp_reg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             wrap
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= RESET_VAL;
         wrap <= 1'b0;
      end else begin
         case (op)
            OP_CLR: begin
               q    <= '0;
               wrap <= 1'b0;
            end
            OP_LOAD: begin
               q    <= data_in;
               wrap <= 1'b0;
            end
            OP_INC: begin
               q <= q + 1'b1;
               // sticky: only clr/load/reset drop it
               if (&q)
                  wrap <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign zero = (q == '0);

endmodule

// File: rtl/gp_reg_bank.sv
// Bank of NUM_REGS general-purpose registers on a shared
// write bus with a zero-latency read mux.
module gp_reg_bank
   import gp_reg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NUM_REGS = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          data_in,
   input  logic [NUM_REGS-1:0]       load_en,
   input  logic [NUM_REGS-1:0]       clr_en,
   input  logic [NUM_REGS-1:0]       inc_en,
   input  logic [SEL_W-1:0]          rd_sel,
   output logic [WIDTH-1:0]          bus_out,
   output logic [NUM_REGS*WIDTH-1:0] reg_flat,
   output logic [NUM_REGS-1:0]       zero_flag,
   output logic [NUM_REGS-1:0]       wrap_flag
);

   logic [WIDTH-1:0] q [NUM_REGS];

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      gp_reg_cell #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_cell (
         .clk     (clk),
         .reset   (reset),
         .op      (strobe_op(clr_en[i], load_en[i], inc_en[i])),
         .data_in (data_in),
         .q       (q[i]),
         .zero    (zero_flag[i]),
         .wrap    (wrap_flag[i])
      );
      assign reg_flat[i*WIDTH +: WIDTH] = q[i];
   end

   // out-of-range selects fall through to zero
   always_comb begin
      bus_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_sel == i[SEL_W-1:0])
            bus_out = q[i];
      end
   end

endmodule

// File: tb/tb_gp_reg_bank.sv
// Directed bench for gp_reg_bank: default build, a
// RESET_VAL=0100 build and a five-register build.
module tb_gp_reg_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic [3:0]  load_en, clr_en, inc_en;
   logic [1:0]  rd_sel;
   logic [15:0] bus_out, rv_bus;
   logic [63:0] reg_flat, rv_flat;
   logic [3:0]  zero_flag, wrap_flag, rv_zero, rv_wrap;

   logic        reset5;
   logic [15:0] data5;
   logic [4:0]  load5, clr5, inc5;
   logic [2:0]  sel5;
   logic [15:0] bus5;
   logic [79:0] flat5;
   logic [4:0]  zero5, wrap5;

   int vectors = 0;
   int fails = 0;
   logic [15:0] exp_rd [4];
   logic [15:0] vals5 [5];
   logic [15:0] exp5;

   always #5 clk = ~clk;

   gp_reg_bank dut (
      .clk(clk), .reset(reset), .data_in(data_in),
      .load_en(load_en), .clr_en(clr_en), .inc_en(inc_en),
      .rd_sel(rd_sel), .bus_out(bus_out), .reg_flat(reg_flat),
      .zero_flag(zero_flag), .wrap_flag(wrap_flag)
   );

   gp_reg_bank #(.RESET_VAL(16'h0100)) dut_rv (
      .clk(clk), .reset(reset), .data_in(data_in),
      .load_en(load_en), .clr_en(clr_en), .inc_en(inc_en),
      .rd_sel(rd_sel), .bus_out(rv_bus), .reg_flat(rv_flat),
      .zero_flag(rv_zero), .wrap_flag(rv_wrap)
   );

   gp_reg_bank #(.NUM_REGS(5)) dut5 (
      .clk(clk), .reset(reset5), .data_in(data5),
      .load_en(load5), .clr_en(clr5), .inc_en(inc5),
      .rd_sel(sel5), .bus_out(bus5), .reg_flat(flat5),
      .zero_flag(zero5), .wrap_flag(wrap5)
   );

   task automatic chk(input string tag,
                      input logic [79:0] obs,
                      input logic [79:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load_en = '0;
      clr_en  = '0;
      inc_en  = '0;
   endtask

   initial begin
      reset = 1'b1; data_in = '0; rd_sel = '0; idle();
      reset5 = 1'b1; data5 = '0; sel5 = '0;
      load5 = '0; clr5 = '0; inc5 = '0;
      tick();
      chk("rst_flat", 80'(reg_flat), 80'h0);
      chk("rst_zero", 80'(zero_flag), 80'hF);
      chk("rst_wrap", 80'(wrap_flag), 80'h0);
      chk("rv_rst_flat", 80'(rv_flat), 80'h0100_0100_0100_0100);
      chk("rv_rst_zero", 80'(rv_zero), 80'h0);

      // 1: load reg1, no bypass in the write cycle
      reset = 1'b0; reset5 = 1'b0;
      load_en = 4'b0010; data_in = 16'hBEEF; rd_sel = 2'd1;
      #1;
      chk("t1_nobypass", 80'(bus_out), 80'h0);
      tick();
      chk("t1_bus", 80'(bus_out), 80'hBEEF);
      chk("t1_zero", 80'(zero_flag), 80'hD);
      chk("t1_wrap", 80'(wrap_flag), 80'h0);

      // 2: reg2 wraps through all-ones
      load_en = 4'b0100; data_in = 16'hFFFE; rd_sel = 2'd2;
      tick();
      idle(); inc_en = 4'b0100;
      tick();
      chk("t2_ffff", 80'(bus_out), 80'hFFFF);
      chk("t2_wrap0", 80'(wrap_flag), 80'h0);
      chk("t2_zero0", 80'(zero_flag), 80'h9);
      tick();
      chk("t2_0000", 80'(bus_out), 80'h0);
      chk("t2_wrap1", 80'(wrap_flag), 80'h4);
      chk("t2_zero1", 80'(zero_flag), 80'hD);
      tick();
      chk("t2_0001", 80'(bus_out), 80'h1);
      chk("t2_sticky", 80'(wrap_flag), 80'h4);
      chk("t2_zero2", 80'(zero_flag), 80'h9);

      // 3: clr beats load beats inc
      idle();
      clr_en = 4'b1000; load_en = 4'b1000; inc_en = 4'b1000;
      data_in = 16'h1234; rd_sel = 2'd3;
      tick();
      chk("t3_clr", 80'(bus_out), 80'h0);
      chk("t3_wrap", 80'(wrap_flag[3]), 80'h0);
      clr_en = '0;
      tick();
      chk("t3_load", 80'(bus_out), 80'h1234);

      // 5: mixed strobes in one cycle
      idle(); load_en = 4'b0010; data_in = 16'h0007;
      tick();
      idle();
      load_en = 4'b0001; inc_en = 4'b0010; clr_en = 4'b1000;
      data_in = 16'h0005;
      tick();
      chk("t5_flat", 80'(reg_flat), 80'h0000_0001_0008_0005);
      chk("t5_wrap", 80'(wrap_flag), 80'h4);
      idle(); load_en = 4'b0100; data_in = 16'h00AB;
      tick();
      chk("t5_load_unwrap", 80'(wrap_flag), 80'h0);

      // 6: combinational read sweep
      idle();
      exp_rd = '{16'h0005, 16'h0008, 16'h00AB, 16'h0000};
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         chk("t6_sweep", 80'(bus_out), 80'(exp_rd[i]));
      end

      // 4: reset wins over strobes, after a wrap on reg3
      load_en = 4'b1000; data_in = 16'hFFFF;
      tick();
      idle(); inc_en = 4'b1000;
      tick();
      chk("t4_prewrap", 80'(wrap_flag), 80'h8);
      idle();
      reset = 1'b1; load_en = 4'b1111; data_in = 16'hAAAA;
      tick();
      chk("t4_flat", 80'(reg_flat), 80'h0);
      chk("t4_wrap", 80'(wrap_flag), 80'h0);
      chk("t4_zero", 80'(zero_flag), 80'hF);
      chk("t4_rv_flat", 80'(rv_flat), 80'h0100_0100_0100_0100);
      chk("t4_rv_zero", 80'(rv_zero), 80'h0);
      chk("t4_rv_wrap", 80'(rv_wrap), 80'h0);
      reset = 1'b0; idle();

      // 6b: five-register build, out-of-range selects
      vals5 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      for (int i = 0; i < 5; i++) begin
         load5 = 5'(1 << i); data5 = vals5[i];
         tick();
      end
      load5 = '0;
      for (int i = 0; i < 8; i++) begin
         sel5 = 3'(i);
         #1;
         exp5 = (i < 5) ? vals5[i] : 16'h0;
         chk("t6_sweep5", 80'(bus5), 80'(exp5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
